byte_packer: RTL and testbench

BYTE_PACKER -- requirements
Module: byte_packer

---
 rtl/byte_packer_if.sv | 21 ++
 rtl/byte_packer.sv | 69 ++++++
 tb/tb_byte_packer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/byte_packer_if.sv
// byte_packer_if: byte-in / word-out handshake bundle around byte_packer
//   master: byte producer + word consumer (drives header_flag, write_en, packet_in, flush, data_ready)
//   slave : the packer (drives in_ready, all_data, data_valid, data_len, overflow)
interface byte_packer_if #(
   parameter int BYTE_W = 8,
   parameter int BYTES_PER_WORD = 4
);
   localparam int LW = $clog2(BYTES_PER_WORD + 1);
   logic header_flag, write_en, flush, in_ready, data_valid, data_ready, overflow;
   logic [BYTE_W-1:0] packet_in;
   logic [BYTE_W*BYTES_PER_WORD-1:0] all_data;
   logic [LW-1:0] data_len;
   modport master (
      output header_flag, write_en, packet_in, flush, data_ready,
      input  in_ready, all_data, data_valid, data_len, overflow
   );
   modport slave (
      input  header_flag, write_en, packet_in, flush, data_ready,
      output in_ready, all_data, data_valid, data_len, overflow
   );
endinterface

// File: rtl/byte_packer.sv
// byte_packer: packs BYTE_W-wide bytes into BYTES_PER_WORD-lane words with flush, packet headers and overflow flag
//   clk_50, reset : clock and synchronous active-high reset
//   bus (slave)   : byte input (header_flag, write_en, packet_in, flush, in_ready),
//                   word output (all_data, data_len, data_valid, data_ready), sticky overflow
module byte_packer #(
   parameter int BYTE_W = 8,
   parameter int BYTES_PER_WORD = 4,
   parameter bit MSB_FIRST = 1'b0
) (
   input logic clk_50,
   input logic reset,
   byte_packer_if.slave bus
);
   localparam int N = BYTES_PER_WORD;
   localparam int CW = $clog2(N);
   localparam int LW = $clog2(N + 1);
   logic [N-1:0][BYTE_W-1:0] acc_q, acc_d, acc_w;
   logic [CW-1:0] cnt_q, cnt_d, lane;
   logic [N*BYTE_W-1:0] all_data_q, all_data_d;
   logic [LW-1:0] data_len_q, data_len_d;
   logic flush_pend_q, flush_pend_d, data_valid_q, data_valid_d, overflow_q, overflow_d;
   logic slot_free, in_ready, accept, last, complete, flush_emit, emit;
   always_comb begin
      slot_free = !data_valid_q || bus.data_ready;
      last = cnt_q == CW'(N - 1);
      // a pending flush freezes the accumulator until its word has been emitted
      in_ready = !bus.header_flag && !flush_pend_q && (!last || slot_free);
      accept = bus.write_en && in_ready;
      complete = accept && last;
      flush_emit = flush_pend_q && slot_free && !complete;
      emit = !bus.header_flag && (complete || flush_emit);
      lane = MSB_FIRST ? CW'(N - 1) - cnt_q : cnt_q;
      acc_w = acc_q;
      if (accept) acc_w[lane] = bus.packet_in;
      // unwritten lanes are already zero because acc clears on every emit/header
      acc_d = (bus.header_flag || emit) ? '0 : acc_w;
      cnt_d = (bus.header_flag || emit) ? '0 : cnt_q + CW'(accept);
      flush_pend_d = !bus.header_flag && !flush_emit &&
                     (flush_pend_q || (bus.flush && !complete && (cnt_q != '0 || accept)));
      all_data_d = emit ? acc_w : all_data_q;
      data_len_d = emit ? (complete ? LW'(N) : LW'(cnt_q)) : data_len_q;
      data_valid_d = emit || (data_valid_q && !bus.data_ready);
      overflow_d = overflow_q || (bus.write_en && !in_ready && !bus.header_flag);
   end
   always_ff @(posedge clk_50) begin
      if (reset) begin
         acc_q <= '0;
         cnt_q <= '0;
         flush_pend_q <= 1'b0;
         all_data_q <= '0;
         data_len_q <= '0;
         data_valid_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         flush_pend_q <= flush_pend_d;
         all_data_q <= all_data_d;
         data_len_q <= data_len_d;
         data_valid_q <= data_valid_d;
         overflow_q <= overflow_d;
      end
   end
   assign bus.in_ready = in_ready;
   assign bus.all_data = all_data_q;
   assign bus.data_len = data_len_q;
   assign bus.data_valid = data_valid_q;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_byte_packer.sv
// tb_byte_packer: random + directed check of byte_packer (LSB- and MSB-first) against a queue-based model
module tb_byte_packer;
   localparam int N = 4;
   logic clk_50 = 1'b0;
   logic reset = 1'b1;
   logic hdr, we, fl, rdy;
   logic [7:0] din;
   always #5 clk_50 = ~clk_50;
   byte_packer_if #(.BYTE_W(8), .BYTES_PER_WORD(N)) bif0 ();
   byte_packer_if #(.BYTE_W(8), .BYTES_PER_WORD(N)) bif1 ();
   byte_packer #(.BYTE_W(8), .BYTES_PER_WORD(N), .MSB_FIRST(1'b0)) dut0 (.clk_50(clk_50), .reset(reset), .bus(bif0));
   byte_packer #(.BYTE_W(8), .BYTES_PER_WORD(N), .MSB_FIRST(1'b1)) dut1 (.clk_50(clk_50), .reset(reset), .bus(bif1));
   assign bif0.header_flag = hdr;
   assign bif0.write_en = we;
   assign bif0.packet_in = din;
   assign bif0.flush = fl;
   assign bif0.data_ready = rdy;
   assign bif1.header_flag = hdr;
   assign bif1.write_en = we;
   assign bif1.packet_in = din;
   assign bif1.flush = fl;
   assign bif1.data_ready = rdy;
   logic [31:0] o_data [2];
   logic [2:0] o_len [2];
   logic o_vld [2];
   logic o_ir [2];
   logic o_ov [2];
   assign o_data[0] = bif0.all_data;
   assign o_data[1] = bif1.all_data;
   assign o_len[0] = bif0.data_len;
   assign o_len[1] = bif1.data_len;
   assign o_vld[0] = bif0.data_valid;
   assign o_vld[1] = bif1.data_valid;
   assign o_ir[0] = bif0.in_ready;
   assign o_ir[1] = bif1.in_ready;
   assign o_ov[0] = bif0.overflow;
   assign o_ov[1] = bif1.overflow;

   int errs = 0;
   int checks = 0;
   bit chk_en = 1'b0;
   logic [31:0] got [$];
   int got_len [$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack(input logic [7:0] b [$], input bit msb);
      logic [31:0] w;
      w = '0;
      foreach (b[i]) w = w | (32'(b[i]) << (8 * (msb ? N - 1 - i : i)));
      return w;
   endfunction

   // model: bytes of the word in progress, pending-flush flag, sticky overflow, and the held output word
   logic [7:0] cur [$];
   logic [7:0] ob [$];
   bit fp, ov, vld;
   initial begin
      bit slot, ir, emit;
      fp = 0;
      ov = 0;
      vld = 0;
      forever begin
         @(negedge clk_50);
         slot = !vld || rdy;
         ir = !hdr && !fp && (cur.size() != N - 1 || slot);
         if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
               chk("in_ready", 64'(o_ir[d]), 64'(ir));
               chk("data_valid", 64'(o_vld[d]), 64'(vld));
               chk("overflow", 64'(o_ov[d]), 64'(ov));
               if (vld) begin
                  chk(d == 0 ? "all_data_lsb" : "all_data_msb", 64'(o_data[d]), 64'(pack(ob, d == 1)));
                  chk("data_len", 64'(o_len[d]), 64'(ob.size()));
               end
            end
            if (o_vld[0] && rdy) begin
               got.push_back(o_data[0]);
               got_len.push_back(int'(o_len[0]));
            end
         end
         if (reset) begin
            cur.delete();
            ob.delete();
            fp = 0;
            ov = 0;
            vld = 0;
         end else begin
            if (we && !ir && !hdr) ov = 1;
            if (hdr) begin
               cur.delete();
               fp = 0;
               if (rdy) vld = 0;
            end else begin
               emit = 0;
               if (we && ir) cur.push_back(din);
               if (cur.size() == N || (fp && slot)) begin
                  ob = cur;
                  cur.delete();
                  fp = 0;
                  emit = 1;
               end else if (fl && cur.size() > 0) fp = 1;
               if (emit) vld = 1;
               else if (rdy) vld = 0;
            end
         end
      end
   end

   task automatic cyc(input bit h, input bit w, input logic [7:0] b, input bit f, input bit r);
      hdr = h;
      we = w;
      din = b;
      fl = f;
      rdy = r;
      @(posedge clk_50);
      #1;
   endtask
   task automatic wr(input logic [7:0] b);
      cyc(1'b0, 1'b1, b, 1'b0, 1'b1);
   endtask
   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
   endtask
   task automatic do_reset;
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
   endtask

   initial begin
      hdr = 0;
      we = 0;
      din = 0;
      fl = 0;
      rdy = 1;
      @(posedge clk_50);
      #1;
      chk_en = 1'b1;
      chk("rst_all_data", 64'(bif0.all_data), 64'h0);
      chk("rst_data_len", 64'(bif0.data_len), 64'h0);
      chk("rst_data_valid", 64'(bif0.data_valid), 64'h0);
      chk("rst_overflow", 64'(bif0.overflow), 64'h0);
      chk("rst_in_ready", 64'(bif0.in_ready), 64'h1);
      hdr = 1;
      #1;
      chk("rst_in_ready_hdr", 64'(bif0.in_ready), 64'h0);
      hdr = 0;
      reset = 0;
      idle(1);
      got.delete();
      got_len.delete();
      wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
      chk("full_lsb", 64'(bif0.all_data), 64'h44332211);
      chk("full_msb", 64'(bif1.all_data), 64'h11223344);
      chk("full_len", 64'(bif0.data_len), 64'd4);
      chk("full_valid", 64'(bif0.data_valid), 64'h1);
      idle(2);
      chk("full_once", 64'(got.size()), 64'd1);
      got.delete();
      wr(8'hAA); wr(8'hBB);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      idle(1);
      chk("flush_data", 64'(bif0.all_data), 64'h0000BBAA);
      chk("flush_len", 64'(bif0.data_len), 64'd2);
      idle(1);
      wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
      chk("after_flush", 64'(bif0.all_data), 64'h04030201);
      idle(2);
      do_reset();
      got.delete();
      for (int i = 1; i <= 7; i++) cyc(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      hdr = 0; we = 1; din = 8'h08; fl = 0; rdy = 0;
      #1;
      chk("stall_in_ready", 64'(bif0.in_ready), 64'h0);
      @(posedge clk_50);
      #1;
      chk("stall_overflow", 64'(bif0.overflow), 64'h1);
      chk("stall_hold", 64'(bif0.all_data), 64'h04030201);
      chk("stall_valid", 64'(bif0.data_valid), 64'h1);
      cyc(1'b0, 1'b1, 8'h08, 1'b0, 1'b1);
      chk("stall_second", 64'(bif0.all_data), 64'h08070605);
      idle(2);
      chk("stall_count", 64'(got.size()), 64'd2);
      if (got.size() == 2) chk("stall_first", 64'(got[0]), 64'h04030201);
      do_reset();
      got.delete();
      wr(8'h55); wr(8'h66);
      cyc(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
      wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
      idle(2);
      chk("hdr_count", 64'(got.size()), 64'd1);
      if (got.size() == 1) chk("hdr_word", 64'(got[0]), 64'h04030201);
      chk("hdr_overflow", 64'(bif0.overflow), 64'h0);
      do_reset();
      got.delete();
      wr(8'h99); wr(8'h98);
      do_reset();
      wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
      idle(2);
      chk("rstmid_count", 64'(got.size()), 64'd1);
      if (got.size() == 1) chk("rstmid_word", 64'(got[0]), 64'h04030201);
      do_reset();
      repeat (4000) begin
         reset = ($urandom_range(0, 199) == 0);
         cyc($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, 8'($urandom),
             $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
      end
      reset = 0;
      idle(3);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
